alu_core: RTL and testbench

- 4-bit unsigned arithmetic unit: add, subtract, multiply, divide, selected by a 2-bit opcode.
- Registered outputs plus a fault indicator for illegal operations (divide by zero).
- Add/sub/mul complete in one cycle. Divide uses a multi-cycle iterative restoring divider.
- Sits behind a simple valid/ready handshake as the datapath leaf of a small DFT-study design.

---
 rtl/alu_core.sv | 207 ++++++++++++++++++++
 tb/tb_alu_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_core
//  Purpose  : Unsigned WIDTH-bit arithmetic unit (add/sub/mul/div) behind a
//             valid/ready handshake. Add, sub, mul and divide-by-zero finish
//             in one cycle. A non-zero divide runs an iterative restoring
//             divider that produces one quotient bit per cycle, MSB first.
//  Ports    : clk, rst_n        - clock, asynchronous active-low reset
//             in_valid/in_ready - operation handshake (ready = not busy)
//             a, b, op          - operands, opcode (00 add,01 sub,10 mul,11 div)
//             c, rem            - result / quotient, division remainder
//             carry, ovf, fault - carry|borrow, multiply overflow, div-by-zero
//             out_valid         - one-cycle pulse marking a new result
//  Revision : 1.0  initial release
// ============================================================================
module alu_core #(
  parameter int WIDTH      = 4,
  parameter int DIV_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] rem,
  output logic             carry,
  output logic             ovf,
  output logic             fault,
  output logic             out_valid
);

  localparam int         CNT_W   = $clog2(DIV_CYCLES + 1);
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  // Holds the not-yet-consumed dividend bits; quotient bits shift in at the LSB.
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   part_q, part_d;

  logic [WIDTH-1:0]   c_q, c_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               fault_q, fault_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic               qbit;
  logic [WIDTH-1:0]   part_next;
  logic [WIDTH-1:0]   quo_next;

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    // Top bit of the extended difference is the borrow (a < b).
    diff = {1'b0, a} - {1'b0, b};
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  end

  // One restoring-division step: bring down the next dividend bit, try to
  // subtract the divisor and keep the difference only when it does not go
  // negative.
  always_comb begin
    shifted   = {part_q, quo_q[WIDTH-1]};
    trial     = shifted - {1'b0, divisor_q};
    qbit      = (shifted >= {1'b0, divisor_q});
    part_next = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next  = {quo_q[WIDTH-2:0], qbit};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    divisor_d   = divisor_q;
    quo_d       = quo_q;
    part_d      = part_q;
    c_d         = c_q;
    rem_d       = rem_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    fault_d     = fault_q;
    out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Every result clears flags that do not apply to its op.
          rem_d   = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          fault_d = 1'b0;
          case (op)
            OP_ADD: begin
              c_d         = sum[WIDTH-1:0];
              carry_d     = sum[WIDTH];
              out_valid_d = 1'b1;
            end
            OP_SUB: begin
              c_d         = diff[WIDTH-1:0];
              carry_d     = diff[WIDTH];
              out_valid_d = 1'b1;
            end
            OP_MUL: begin
              c_d         = prod[WIDTH-1:0];
              ovf_d       = |prod[2*WIDTH-1:WIDTH];
              out_valid_d = 1'b1;
            end
            default: begin
              if (b == '0) begin
                c_d         = '1;
                rem_d       = a;
                fault_d     = 1'b1;
                out_valid_d = 1'b1;
              end else begin
                // Result registers keep their previous values until the
                // divide completes.
                c_d       = c_q;
                rem_d     = rem_q;
                carry_d   = carry_q;
                ovf_d     = ovf_q;
                fault_d   = fault_q;
                state_d   = ST_BUSY;
                cnt_d     = '0;
                divisor_d = b;
                quo_d     = a;
                part_d    = '0;
              end
            end
          endcase
        end
      end

      ST_BUSY: begin
        part_d = part_next;
        quo_d  = quo_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
          state_d     = ST_IDLE;
          c_d         = quo_next;
          rem_d       = part_next;
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
          fault_d     = 1'b0;
          out_valid_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      divisor_q   <= '0;
      quo_q       <= '0;
      part_q      <= '0;
      c_q         <= '0;
      rem_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      fault_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      divisor_q   <= divisor_d;
      quo_q       <= quo_d;
      part_q      <= part_d;
      c_q         <= c_d;
      rem_q       <= rem_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      fault_q     <= fault_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign c         = c_q;
  assign rem       = rem_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign fault     = fault_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_core
//  Purpose  : Self-checking bench for alu_core: a table of directed vectors,
//             hand-written multi-cycle sequences (busy/ignore, operand
//             hold, back-to-back, reset mid-divide) and random operations
//             compared against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a, b;
  logic [1:0] op;
  logic [3:0] c, rem;
  logic       carry, ovf, fault, out_valid;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] c;
    logic [3:0] rem;
    logic       carry;
    logic       ovf;
    logic       fault;
    int         lat;    // edges after the accept edge before out_valid shows
  } vec_t;

  vec_t tbl [0:11];

  alu_core #(.WIDTH(4), .DIV_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .c         (c),
    .rem       (rem),
    .carry     (carry),
    .ovf       (ovf),
    .fault     (fault),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation's definition.
  function automatic vec_t model(input logic [3:0] xa, input logic [3:0] xb,
                                 input logic [1:0] xop);
    vec_t v;
    int   ia, ib, r;
    ia = int'(xa);
    ib = int'(xb);
    v.a = xa; v.b = xb; v.op = xop;
    v.c = '0; v.rem = '0; v.carry = 0; v.ovf = 0; v.fault = 0; v.lat = 0;
    case (xop)
      2'd0: begin r = ia + ib; v.c = 4'(r % 16); v.carry = (r > 15); end
      2'd1: begin r = ia - ib; v.c = 4'((r + 16) % 16); v.carry = (ia < ib); end
      2'd2: begin r = ia * ib; v.c = 4'(r % 16); v.ovf = ((r / 16) != 0); end
      default: begin
        if (ib == 0) begin
          v.c = 4'd15; v.rem = xa; v.fault = 1;
        end else begin
          v.c = 4'(ia / ib); v.rem = 4'(ia % ib); v.lat = 4;
        end
      end
    endcase
    return v;
  endfunction

  task automatic run_op(input vec_t v, input string tag);
    int n;
    a = v.a; b = v.b; op = v.op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 12) begin
      chk({tag, "_busy_ready"}, in_ready, 0);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_latency"}, n, v.lat);
    chk({tag, "_c"}, c, v.c);
    chk({tag, "_rem"}, rem, v.rem);
    chk({tag, "_carry"}, carry, v.carry);
    chk({tag, "_ovf"}, ovf, v.ovf);
    chk({tag, "_fault"}, fault, v.fault);
    chk({tag, "_ready"}, in_ready, 1);
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, out_valid, 0);
    chk({tag, "_c_hold"}, c, v.c);
  endtask

  initial begin
    vec_t v;
    int   n;

    tbl[0]  = '{4'd3,  4'd4, 2'd0, 4'd7,  4'd0, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{4'd15, 4'd15,2'd0, 4'd14, 4'd0, 1'b1, 1'b0, 1'b0, 0};
    tbl[2]  = '{4'd0,  4'd1, 2'd1, 4'd15, 4'd0, 1'b1, 1'b0, 1'b0, 0};
    tbl[3]  = '{4'd9,  4'd4, 2'd1, 4'd5,  4'd0, 1'b0, 1'b0, 1'b0, 0};
    tbl[4]  = '{4'd3,  4'd5, 2'd2, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0, 0};
    tbl[5]  = '{4'd7,  4'd6, 2'd2, 4'd10, 4'd0, 1'b0, 1'b1, 1'b0, 0};
    tbl[6]  = '{4'd13, 4'd4, 2'd3, 4'd3,  4'd1, 1'b0, 1'b0, 1'b0, 4};
    tbl[7]  = '{4'd9,  4'd0, 2'd3, 4'd15, 4'd9, 1'b0, 1'b0, 1'b1, 0};
    tbl[8]  = '{4'd1,  4'd1, 2'd0, 4'd2,  4'd0, 1'b0, 1'b0, 1'b0, 0};
    tbl[9]  = '{4'd0,  4'd5, 2'd3, 4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 4};
    tbl[10] = '{4'd15, 4'd15,2'd2, 4'd1,  4'd0, 1'b0, 1'b1, 1'b0, 0};
    tbl[11] = '{4'd15, 4'd1, 2'd3, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0, 4};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_c", c, 0);
    chk("rst_rem", rem, 0);
    chk("rst_flags", {carry, ovf, fault}, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table (order matters: the add after 9/0 checks fault clears).
    for (int i = 0; i < 12; i++) run_op(tbl[i], $sformatf("tbl%0d", i));

    // Divide with in_valid held and operands changed while busy: the busy
    // request is ignored and the in-flight result is unaffected.
    a = 4'd13; b = 4'd4; op = 2'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 4'd2; b = 4'd1; op = 2'd0;
    n = 0;
    while (!out_valid && n < 12) begin
      chk("hold_busy_ready", in_ready, 0);
      @(posedge clk); #1;
      n++;
    end
    chk("hold_latency", n, 4);
    chk("hold_c", c, 3);
    chk("hold_rem", rem, 1);
    chk("hold_ready_with_valid", in_ready, 1);
    // Back-to-back: new op accepted on the edge right after the divide result.
    a = 4'd2; b = 4'd3; op = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b_div_then_add_valid", out_valid, 1);
    chk("b2b_div_then_add_c", c, 5);

    // Single-cycle ops every cycle.
    a = 4'd1; b = 4'd2; op = 2'd0;
    @(posedge clk); #1;
    chk("stream0_valid", out_valid, 1);
    chk("stream0_c", c, 3);
    a = 4'd5; b = 4'd6; op = 2'd0;
    @(posedge clk); #1;
    chk("stream1_valid", out_valid, 1);
    chk("stream1_c", c, 11);
    a = 4'd10; b = 4'd3; op = 2'd1;
    @(posedge clk); #1;
    chk("stream2_valid", out_valid, 1);
    chk("stream2_c", c, 7);
    chk("stream2_ready", in_ready, 1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream_end_valid", out_valid, 0);
    chk("stream_end_hold", c, 7);

    // Reset in the middle of a divide: aborted, no result, asynchronous clear.
    a = 4'd15; b = 4'd2; op = 2'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_c", c, 0);
    chk("midrst_rem", rem, 0);
    chk("midrst_flags", {carry, ovf, fault}, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_result", out_valid, 0);
    end
    chk("midrst_c_after", c, 0);
    run_op(model(4'd15, 4'd2, 2'd3), "postrst_div");

    // Random operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      logic [3:0] ra, rb;
      logic [1:0] rop;
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rop = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) rb = 4'd0;
      v = model(ra, rb, rop);
      run_op(v, $sformatf("rnd%0d_op%0d_%0d_%0d", i, rop, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
